// File: rtl/im2col_block.sv
// Im2col front-end: loads one image, builds the im2col (or FC pass-through) matrix,
// then streams it slice by slice with a diagonal skew. Optional macro: IM2COL_PARAM_CHECK_EN.
module im2col_block #(
   parameter int DATA_SIZE        = 8,
   parameter int MAX_SYS_PORT     = 16,
   parameter int FILTER_WIDTH     = 2,
   parameter int FILTER_HEIGHT    = 2,
   parameter int MAX_DEPTH_IMAGE  = 16,
   parameter int MAX_DEPTH_OUTPUT = 36,
   parameter int MAX_DEPTH_SLICE  = 12,
   parameter int MAX_SYS_HEIGHT   = 3,
   parameter int MAX_SYS_WIDTH    = 6
) (
   input  logic                              i_clk,
   input  logic                              i_n_reset,
   input  logic                              i_set_param,
   input  logic                              i_start_mac,
   output logic                              o_done,
   output logic                              o_image_ready,
   input  logic                              i_mode_conv,
   input  logic [7:0]                        i_image_width,
   input  logic [7:0]                        i_image_height,
   input  logic [7:0]                        i_image_channel,
   input  logic [7:0]                        i_slice_width,
   input  logic [7:0]                        i_slice_height,
   input  logic [7:0]                        i_slice_number,
   output logic                              o_en_ram,
   input  logic                              i_ram_read_done,
   input  logic [DATA_SIZE-1:0]              i_ram_to_i2c_data,
   input  logic                              i_ram_to_i2c_valid,
   output logic [DATA_SIZE*MAX_SYS_PORT-1:0] o_data,
   output logic                              o_valid
);
   localparam int MAX_DEPTH_SYS = MAX_SYS_HEIGHT * MAX_SYS_WIDTH;
   localparam int MAX_CYCLE     = MAX_SYS_HEIGHT + MAX_SYS_WIDTH - 1;
   localparam int IMG_AW        = $clog2(MAX_DEPTH_IMAGE);
   localparam int OUT_AW        = $clog2(MAX_DEPTH_OUTPUT);
   localparam int OFF_W         = $clog2(MAX_DEPTH_SYS);
   localparam int CYC_W         = $clog2(MAX_CYCLE + 1);

   typedef enum logic [2:0] {IDLE, LOAD, BUILD, READY, FEED, DONE} state_t;
   state_t r_state, w_next;

   logic                        r_mode;
   logic [7:0]                  r_w, r_h, r_c, r_sw, r_sh, r_ns;
   logic signed [DATA_SIZE-1:0] r_img [MAX_DEPTH_IMAGE];
   logic signed [DATA_SIZE-1:0] r_mat [MAX_DEPTH_OUTPUT];
   logic [31:0]                 r_wcnt, r_midx, r_base;
   logic [7:0]                  r_k, r_fx, r_fy, r_ch, r_ox, r_s;
   logic [15:0]                 r_oy;
   logic [CYC_W-1:0]            r_t;

   logic [31:0] w_total, w_out_total, w_ow, w_oh, w_src, w_slice_elems;
   logic [31:0] w_d, w_addr;
   logic [OFF_W-1:0] w_off;
   logic        w_row_ok, w_slice_end, w_accept;
   logic signed [DATA_SIZE-1:0] w_elem;

`ifdef IM2COL_PARAM_CHECK_EN
   logic w_param_ok;
   assign w_param_ok =
      (32'(i_image_width) * 32'(i_image_height) * 32'(i_image_channel) <= 32'(MAX_DEPTH_IMAGE)) &&
      (32'(i_slice_number) * 32'(i_slice_height) * 32'(i_slice_width) <= 32'(MAX_DEPTH_OUTPUT)) &&
      (32'(i_slice_height) <= 32'(MAX_SYS_HEIGHT)) && (32'(i_slice_width) <= 32'(MAX_SYS_WIDTH)) &&
      (!i_mode_conv || ((32'(i_image_width) >= 32'(FILTER_WIDTH)) &&
                        (32'(i_image_height) >= 32'(FILTER_HEIGHT)))) &&
      (i_image_width != 8'd0) && (i_image_height != 8'd0) && (i_image_channel != 8'd0) &&
      (i_slice_width != 8'd0) && (i_slice_height != 8'd0) && (i_slice_number != 8'd0);
   assign w_accept = i_set_param && w_param_ok;
`else
   assign w_accept = i_set_param;
`endif

   assign w_total       = 32'(r_w) * 32'(r_h) * 32'(r_c);
   assign w_out_total   = 32'(r_ns) * 32'(r_sh) * 32'(r_sw);
   assign w_slice_elems = 32'(r_sh) * 32'(r_sw);
   assign w_ow          = 32'(r_w) - 32'(FILTER_WIDTH) + 32'd1;
   assign w_oh          = 32'(r_h) - 32'(FILTER_HEIGHT) + 32'd1;
   assign w_slice_end   = (32'(r_t) == 32'(r_sh) + 32'(r_sw) - 32'd2);

   // Source address of the matrix element currently being built
   assign w_src    = r_mode ? (32'(r_ch) * 32'(r_w) * 32'(r_h) +
                               (32'(r_oy) + 32'(r_fy)) * 32'(r_w) + 32'(r_ox) + 32'(r_fx))
                            : r_midx;
   assign w_row_ok = !r_mode || (32'(r_oy) < w_oh);
   assign w_elem   = (w_row_ok && (w_src < w_total) && (w_src < 32'(MAX_DEPTH_IMAGE)))
                     ? r_img[w_src[IMG_AW-1:0]] : '0;

   assign o_en_ram      = (r_state == LOAD);
   assign o_image_ready = (r_state == READY);
   assign o_valid       = (r_state == FEED);
   assign o_done        = (r_state == DONE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = LOAD;
         LOAD:    if (i_ram_read_done) w_next = BUILD;
         BUILD:   if (r_midx == w_out_total - 32'd1) w_next = READY;
         READY:   if (i_start_mac) w_next = FEED;
         FEED:    if (w_slice_end && (32'(r_s) == 32'(r_ns) - 32'd1)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Lane i carries row (t - i) of the current slice, column i
   always_comb begin
      o_data = '0;
      w_d    = '0;
      w_off  = '0;
      w_addr = '0;
      if (r_state == FEED) begin
         for (int i = 0; i < MAX_SYS_PORT; i++) begin
            w_d = 32'(r_t) - 32'(i);
            if ((32'(i) < 32'(r_sw)) && (w_d < 32'(r_sh)) &&
                (w_d * 32'(r_sw) + 32'(i) < 32'(MAX_DEPTH_SLICE))) begin
               w_off  = OFF_W'(w_d * 32'(r_sw) + 32'(i));
               w_addr = r_base + 32'(w_off);
               if (w_addr < 32'(MAX_DEPTH_OUTPUT))
                  o_data[DATA_SIZE*i +: DATA_SIZE] = r_mat[w_addr[OUT_AW-1:0]];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_state <= IDLE;
         r_mode  <= 1'b0;
         r_w     <= '0; r_h  <= '0; r_c  <= '0;
         r_sw    <= '0; r_sh <= '0; r_ns <= '0;
         r_wcnt  <= '0; r_midx <= '0; r_base <= '0;
         r_k     <= '0; r_fx <= '0; r_fy <= '0; r_ch <= '0;
         r_ox    <= '0; r_oy <= '0; r_s  <= '0; r_t  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (w_accept) begin
               r_mode <= i_mode_conv;
               r_w    <= i_image_width;  r_h  <= i_image_height; r_c  <= i_image_channel;
               r_sw   <= i_slice_width;  r_sh <= i_slice_height; r_ns <= i_slice_number;
               r_wcnt <= '0; r_midx <= '0; r_base <= '0;
               r_k    <= '0; r_fx <= '0; r_fy <= '0; r_ch <= '0;
               r_ox   <= '0; r_oy <= '0; r_s  <= '0; r_t  <= '0;
            end
            LOAD: if (i_ram_to_i2c_valid && (r_wcnt < w_total)) r_wcnt <= r_wcnt + 32'd1;
            BUILD: begin
               r_midx <= r_midx + 32'd1;
               if (32'(r_k) == 32'(r_sw) - 32'd1) begin
                  r_k  <= '0; r_fx <= '0; r_fy <= '0; r_ch <= '0;
                  if (32'(r_ox) == w_ow - 32'd1) begin
                     r_ox <= '0;
                     r_oy <= r_oy + 16'd1;
                  end else begin
                     r_ox <= r_ox + 8'd1;
                  end
               end else begin
                  r_k <= r_k + 8'd1;
                  if (32'(r_fx) == 32'(FILTER_WIDTH) - 32'd1) begin
                     r_fx <= '0;
                     if (32'(r_fy) == 32'(FILTER_HEIGHT) - 32'd1) begin
                        r_fy <= '0;
                        r_ch <= r_ch + 8'd1;
                     end else begin
                        r_fy <= r_fy + 8'd1;
                     end
                  end else begin
                     r_fx <= r_fx + 8'd1;
                  end
               end
            end
            FEED: if (w_slice_end) begin
               r_t    <= '0;
               r_s    <= r_s + 8'd1;
               r_base <= r_base + w_slice_elems;
            end else begin
               r_t <= r_t + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Buffers hold no reset; the image buffer is cleared when a new load is accepted
   always_ff @(posedge i_clk) begin
      if ((r_state == IDLE) && w_accept) begin
         for (int i = 0; i < MAX_DEPTH_IMAGE; i++) r_img[i] <= '0;
      end else if ((r_state == LOAD) && i_ram_to_i2c_valid && (r_wcnt < w_total) &&
                   (r_wcnt < 32'(MAX_DEPTH_IMAGE))) begin
         r_img[r_wcnt[IMG_AW-1:0]] <= i_ram_to_i2c_data;
      end
      if ((r_state == BUILD) && (r_midx < 32'(MAX_DEPTH_OUTPUT)))
         r_mat[r_midx[OUT_AW-1:0]] <= w_elem;
   end
endmodule

// File: tb/tb_im2col_block.sv
// Bench for im2col_block: directed conv/FC loads with hand-computed skewed streams,
// reset during streaming, set_param ignored while READY, optional parameter rejection.
`timescale 1ns/1ps
module tb_im2col_block;
   localparam int DS = 8;
   localparam int NP = 16;
   localparam int DW = DS * NP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_set_param, i_start_mac, i_mode_conv;
   logic [7:0]    i_image_width, i_image_height, i_image_channel;
   logic [7:0]    i_slice_width, i_slice_height, i_slice_number;
   logic          i_ram_read_done, i_ram_to_i2c_valid;
   logic [DS-1:0] i_ram_to_i2c_data;
   logic          o_done, o_image_ready, o_en_ram, o_valid;
   logic [DW-1:0] o_data;

   always #5 clk = ~clk;

   im2col_block dut (
      .i_clk(clk), .i_n_reset(rst_n),
      .i_set_param(i_set_param), .i_start_mac(i_start_mac),
      .o_done(o_done), .o_image_ready(o_image_ready),
      .i_mode_conv(i_mode_conv),
      .i_image_width(i_image_width), .i_image_height(i_image_height),
      .i_image_channel(i_image_channel),
      .i_slice_width(i_slice_width), .i_slice_height(i_slice_height),
      .i_slice_number(i_slice_number),
      .o_en_ram(o_en_ram), .i_ram_read_done(i_ram_read_done),
      .i_ram_to_i2c_data(i_ram_to_i2c_data), .i_ram_to_i2c_valid(i_ram_to_i2c_valid),
      .o_data(o_data), .o_valid(o_valid)
   );

   // Hand-computed lanes {0,1,2,3} per feed cycle; image 1..15,15 (4x4), 2x2 kernel
   int conv_tab [0:17][0:3] = '{
      '{1,0,0,0}, '{2,2,0,0}, '{3,3,5,0}, '{0,4,6,6}, '{0,0,7,7}, '{0,0,0,8},
      '{5,0,0,0}, '{6,6,0,0}, '{7,7,9,0}, '{0,8,10,10}, '{0,0,11,11}, '{0,0,0,12},
      '{9,0,0,0}, '{10,10,0,0}, '{11,11,13,0}, '{0,12,14,14}, '{0,0,15,15}, '{0,0,0,15}};
   // FC rows {1..4},{5..8},{9..12}
   int fc_tab [0:5][0:3] = '{
      '{1,0,0,0}, '{5,2,0,0}, '{9,6,3,0}, '{0,10,7,4}, '{0,0,11,8}, '{0,0,0,12}};

   logic [DW-1:0] exp_q[$];
   int checks = 0, failures = 0, valid_cnt = 0, done_cnt = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [DW-1:0] v;
      v = '0;
      v[DS*0 +: DS] = DS'(a);
      v[DS*1 +: DS] = DS'(b);
      v[DS*2 +: DS] = DS'(c);
      v[DS*3 +: DS] = DS'(d);
      return v;
   endfunction

   task automatic push_conv();
      for (int r = 0; r < 18; r++)
         exp_q.push_back(pack4(conv_tab[r][0], conv_tab[r][1], conv_tab[r][2], conv_tab[r][3]));
   endtask

   task automatic push_fc();
      for (int r = 0; r < 6; r++)
         exp_q.push_back(pack4(fc_tab[r][0], fc_tab[r][1], fc_tab[r][2], fc_tab[r][3]));
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (o_done) begin
         done_cnt++;
         check("done_valid_low", DW'(o_valid), '0);
      end
      if (o_valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stream_extra: got %h expected no output", o_data);
         end else begin
            check("stream", o_data, exp_q.pop_front());
         end
      end else if (rst_n) begin
         check("quiet_data", o_data, '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_param(input logic mode, input int w, input int h, input int c,
                            input int sw, input int sh, input int ns, input logic exp_en);
      i_mode_conv     = mode;
      i_image_width   = 8'(w);
      i_image_height  = 8'(h);
      i_image_channel = 8'(c);
      i_slice_width   = 8'(sw);
      i_slice_height  = 8'(sh);
      i_slice_number  = 8'(ns);
      i_set_param     = 1'b1;
      tick();
      i_set_param = 1'b0;
      check("en_ram_after_set", DW'(o_en_ram), DW'(exp_en));
   endtask

   task automatic ram_feed(input int n, input int tail);
      for (int i = 0; i < n; i++) begin
         i_ram_to_i2c_data  = DS'(i + 1);
         i_ram_to_i2c_valid = 1'b1;
         tick();
      end
      i_ram_to_i2c_data  = DS'(tail);
      i_ram_to_i2c_valid = 1'b1;
      i_ram_read_done    = 1'b1;
      check("en_ram_at_read_done", DW'(o_en_ram), DW'(1));
      tick();
      i_ram_to_i2c_valid = 1'b0;
      i_ram_read_done    = 1'b0;
      i_ram_to_i2c_data  = '0;
      check("en_ram_after_read_done", DW'(o_en_ram), '0);
   endtask

   task automatic wait_ready(input int exp_cycles, input string name);
      int n;
      n = 0;
      while (!o_image_ready && n < 200) begin
         tick();
         n++;
      end
      check(name, DW'(n), DW'(exp_cycles));
   endtask

   task automatic run_stream(input int exp_valid);
      int v0, d0, n;
      v0 = valid_cnt;
      d0 = done_cnt;
      n  = 0;
      i_start_mac = 1'b1;
      tick();
      i_start_mac = 1'b0;
      check("ready_drops", DW'(o_image_ready), '0);
      check("valid_starts", DW'(o_valid), DW'(1));
      while (!o_done && n < 200) begin
         tick();
         n++;
      end
      check("done_seen", DW'(o_done), DW'(1));
      tick();
      tick();
      check("valid_count", DW'(valid_cnt - v0), DW'(exp_valid));
      check("done_pulses", DW'(done_cnt - d0), DW'(1));
      check("queue_drained", DW'(exp_q.size()), '0);
   endtask

   initial begin
      i_set_param = 0; i_start_mac = 0; i_mode_conv = 0;
      i_image_width = 0; i_image_height = 0; i_image_channel = 0;
      i_slice_width = 0; i_slice_height = 0; i_slice_number = 0;
      i_ram_read_done = 0; i_ram_to_i2c_valid = 0; i_ram_to_i2c_data = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_en_ram", DW'(o_en_ram), '0);
      check("rst_image_ready", DW'(o_image_ready), '0);
      check("rst_done", DW'(o_done), '0);
      check("rst_valid", DW'(o_valid), '0);
      check("rst_data", o_data, '0);
      rst_n = 1'b1;
      tick();

      // Conv load/build, then a set_param while READY that must be ignored
      set_param(1'b1, 4, 4, 1, 4, 3, 3, 1'b1);
      ram_feed(15, 15);
      wait_ready(36, "conv_build_cycles");
      push_conv();
      i_mode_conv = 1'b0;
      i_slice_width = 8'd2;
      i_set_param = 1'b1;
      tick();
      i_set_param = 1'b0;
      check("ready_holds", DW'(o_image_ready), DW'(1));
      check("no_reload", DW'(o_en_ram), '0);
      run_stream(18);

      // FC pass-through
      set_param(1'b0, 4, 3, 1, 4, 3, 1, 1'b1);
      ram_feed(11, 12);
      wait_ready(12, "fc_build_cycles");
      push_fc();
      run_stream(6);

      // Reset in the middle of streaming
      set_param(1'b1, 4, 4, 1, 4, 3, 3, 1'b1);
      ram_feed(15, 15);
      wait_ready(36, "conv2_build_cycles");
      push_conv();
      i_start_mac = 1'b1;
      tick();
      i_start_mac = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", DW'(o_valid), '0);
      check("rst_mid_done", DW'(o_done), '0);
      check("rst_mid_ready", DW'(o_image_ready), '0);
      check("rst_mid_data", o_data, '0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      set_param(1'b0, 4, 3, 1, 4, 3, 1, 1'b1);
      ram_feed(11, 12);
      wait_ready(12, "fc_after_rst_build_cycles");
      push_fc();
      run_stream(6);

`ifdef IM2COL_PARAM_CHECK_EN
      begin
         logic en_seen;
         en_seen = 1'b0;
         set_param(1'b1, 4, 4, 1, 4, 4, 1, 1'b0);
         for (int i = 0; i < 10; i++) begin
            tick();
            if (o_en_ram) en_seen = 1'b1;
         end
         check("param_reject_sh", DW'(en_seen), '0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
